// File: rtl/iddmm_mul_pkg.sv
// Shared constants and types for the IDDMM multiplier arbiter.
package iddmm_mul_pkg;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned MUL_W       = 128;
  localparam int unsigned MUL_LATENCY = 6;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned ID_W        = $clog2(NUM_REQ);

  // One stage of the in-flight tag pipe, travelling alongside the multiplier.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } mul_tag_t;

  // One buffered response: originating requester plus its product.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [MUL_W-1:0] data;
  } mul_rsp_t;

endpackage

// File: rtl/iddmm_mul_rsp_fifo.sv
// First-word-fall-through response FIFO. The output reads as zero while empty.
module iddmm_mul_rsp_fifo
  import iddmm_mul_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = mul_rsp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (cnt_q == '0);
  assign do_pop = pop && !empty;
  assign dout   = empty ? T'('0) : mem[rd_q];

  // Storage write; contents need no reset since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(push && cnt_q == CW'(DEPTH)));
      if (push)   wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      if (push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/iddmm_mul_arbiter.sv
// Round-robin sharing of one non-stallable pipelined multiplier between
// several requesters, with credit-protected in-order response buffering.
// Parameter overrides must agree with iddmm_mul_pkg, whose types size the
// tag pipe and response FIFO.
module iddmm_mul_arbiter #(
  parameter int unsigned NUM_REQ     = iddmm_mul_pkg::NUM_REQ,
  parameter int unsigned MUL_W       = iddmm_mul_pkg::MUL_W,
  parameter int unsigned MUL_LATENCY = iddmm_mul_pkg::MUL_LATENCY,
  parameter int unsigned FIFO_DEPTH  = iddmm_mul_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*MUL_W-1:0]   req_x,
  input  logic [NUM_REQ*MUL_W-1:0]   req_y,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [MUL_W-1:0]           mul_x,
  output logic [MUL_W-1:0]           mul_y,
  input  logic [MUL_W-1:0]           mul_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [MUL_W-1:0]           rsp_data,
  output logic                       busy
);

  import iddmm_mul_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [MUL_W-1:0] x_arr [NUM_REQ];
  logic [MUL_W-1:0] y_arr [NUM_REQ];
  mul_tag_t         tag_q [MUL_LATENCY];
  logic [CNT_W-1:0] cnt_q;
  logic [ID_W-1:0]  ptr_q;
  logic             issue_ok;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand_id;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  mul_rsp_t         fifo_din;
  mul_rsp_t         fifo_dout;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g] = req_x[g*MUL_W +: MUL_W];
    assign y_arr[g] = req_y[g*MUL_W +: MUL_W];
  end

  // Credits count issued-but-not-popped products, so the FIFO can always
  // absorb everything still inside the multiplier.
  assign issue_ok = cnt_q < CNT_W'(FIFO_DEPTH);

  // Round-robin search for the first valid requester starting at ptr_q.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand_id   = '0;
    req_ready = '0;
    if (issue_ok) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand_id = ID_W'((32'(ptr_q) + k) % NUM_REQ);
        if (!grant_any && req_valid[cand_id]) begin
          grant_any          = 1'b1;
          grant_id           = cand_id;
          req_ready[cand_id] = 1'b1;
        end
      end
    end
  end

  // Operand steering to the multiplier; zero when nothing is granted.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if (grant_any) begin
      mul_x = x_arr[grant_id];
      mul_y = y_arr[grant_id];
    end
  end

  // Round-robin pointer and credit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (grant_any)
        ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      if (grant_any && !fifo_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!grant_any && fifo_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Tag pipe; the last stage lines up with the product on mul_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MUL_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{vld: grant_any, id: grant_id};
      for (int unsigned k = 1; k < MUL_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign fifo_push = tag_q[MUL_LATENCY-1].vld;
  assign fifo_din  = '{id: tag_q[MUL_LATENCY-1].id, data: mul_result};
  assign fifo_pop  = rsp_valid && rsp_ready;

  iddmm_mul_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (mul_rsp_t)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_dout.id;
  assign rsp_data  = fifo_dout.data;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_iddmm_mul_arbiter.sv
// Directed bench for iddmm_mul_arbiter with a transaction-level reference model.
module tb_iddmm_mul_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 128;
  localparam int unsigned LAT   = 6;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      mul_x;
  logic [W-1:0]      mul_y;
  logic [W-1:0]      mul_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  int tests = 0;
  int fails = 0;

  iddmm_mul_arbiter #(
    .NUM_REQ     (NREQ),
    .MUL_W       (W),
    .MUL_LATENCY (LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Multiplier: 6-stage pipeline, never reset, so stale products linger.
  logic [W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_x * mul_y;
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[LAT-1];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outstanding count, RR pointer, queue of expected responses.
  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
    longint       due;
  } exp_t;

  exp_t   q[$];
  int     m_cnt = 0;
  int     m_ptr = 0;
  longint cyc   = 0;

  always @(negedge clk) begin
    int           gi;
    int           j;
    logic [NREQ-1:0] eo;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [W-1:0] prod;
    logic         ev;
    logic         pop;
    exp_t         e;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      q.delete();
      m_cnt = 0;
      m_ptr = 0;
    end else begin
      gi = -1;
      eo = '0;
      ex = '0;
      ey = '0;
      if (m_cnt < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (gi < 0 && req_valid[j]) gi = j;
        end
      end
      if (gi >= 0) begin
        eo[gi] = 1'b1;
        ex = req_x[gi*W +: W];
        ey = req_y[gi*W +: W];
      end
      chk("req_ready", req_ready, eo);
      chk("mul_x", mul_x, ex);
      chk("mul_y", mul_y, ey);
      ev = (q.size() > 0) && (q[0].due <= cyc);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_data", rsp_data, q[0].data);
      end
      chk("busy", busy, m_cnt != 0);
      pop = ev && rsp_ready;
      if (pop) void'(q.pop_front());
      if (gi >= 0) begin
        prod   = ex * ey;
        e.id   = gi[1:0];
        e.data = prod;
        e.due  = cyc + 7;
        q.push_back(e);
        m_ptr = (gi + 1) % NREQ;
      end
      if (gi >= 0 && !pop)      m_cnt++;
      else if (gi < 0 && pop)   m_cnt--;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  // Single isolated request; response must appear exactly 7 cycles later.
  task automatic send_check(input string name, input int i, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] expd);
    step();
    req_valid    = '0;
    req_valid[i] = 1'b1;
    set_op(i, x, y);
    neg();
    chk({name, "_grant"}, req_ready, 1 << i);
    step();
    req_valid = '0;
    for (int c = 1; c <= 8; c++) begin
      neg();
      if (c <= 7) chk({name, "_valid"}, rsp_valid, c == 7);
      if (c == 7) begin
        chk({name, "_id"}, rsp_id, i);
        chk({name, "_data"}, rsp_data, expd);
        chk({name, "_busy_hi"}, busy, 1);
      end
      if (c == 8) chk({name, "_busy_lo"}, busy, 0);
      if (c < 8) step();
    end
  endtask

  initial begin
    int ngr;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) step();
    neg();
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    step();
    rst = 1'b0;
    step();

    // Single request, latency and id.
    send_check("t1", 2, 3, 5, 15);

    // Truncation of the product.
    send_check("t4_ones", 0, '1, '1, 1);
    send_check("t4_2p64", 1, {64'h1, 64'h0}, {64'h1, 64'h0}, 0);
    send_check("t4_2p127", 3, {1'b1, 127'h0}, 2, 0);

    // All requesters valid: RR order, one issue per cycle, in-order results.
    for (int c = 0; c < 16; c++) begin
      step();
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) set_op(i, c*4 + i + 1, c*8 + i + 3);
      neg();
      chk("t2_grant", req_ready, 1 << (c % 4));
      if (c >= 7) begin
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_id", rsp_id, (c - 7) % 4);
      end
    end
    step();
    req_valid = '0;
    repeat (10) step();

    // Backpressure: credit limits to 8 outstanding.
    rsp_ready = 1'b0;
    req_valid = '1;
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, c + i + 7, c*3 + i + 11);
      neg();
      if (|req_ready) ngr++;
      step();
    end
    chk("t3_grants", ngr, 8);
    neg();
    chk("t3_stall", req_ready, 0);
    chk("t3_busy", busy, 1);
    step();
    rsp_ready = 1'b1;
    neg();
    chk("t6_nogrant", req_ready, 0);
    chk("t6_pop_valid", rsp_valid, 1);
    chk("t3_first_id", rsp_id, 0);
    step();
    neg();
    chk("t6_grant", |req_ready, 1);
    repeat (8) step();
    req_valid = '0;
    repeat (20) step();

    // Asynchronous reset with products in flight and in the FIFO.
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, i + 21, i + 33);
    repeat (5) step();
    req_valid = '0;
    repeat (3) step();
    chk("t5_pre_valid", rsp_valid, 1);
    chk("t5_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", rsp_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_data", rsp_data, 0);
    chk("t5_async_id", rsp_id, 0);
    chk("t5_async_ready", req_ready, 0);
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    neg();
    chk("t5_stale_present", mul_result != 0, 1);
    for (int c = 0; c < 10; c++) begin
      neg();
      chk("t5_no_valid", rsp_valid, 0);
      chk("t5_idle", busy, 0);
    end
    step();
    req_valid = '1;
    neg();
    chk("t5_ptr0", req_ready, 1);
    step();
    req_valid = '0;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iddmm_mul_arbiter.md
Name: iddmm_mul_arbiter

Overview:
Shares one fully pipelined 128x128->128 multiplier (low-half product, MUL_LATENCY-cycle latency, no stall, no valid) between NUM_REQ requesters in the IDDMM datapath. It round-robin arbitrates valid/ready requests and issues at most one operand pair per cycle. It tracks each in-flight product with a tag shift register and returns results in issue order on one backpressured response port. A credit counter ensures the response FIFO never overflows, because the multiplier pipeline cannot be stalled.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
MUL_W, 128, operand/result width
MUL_LATENCY, 6, clock edges from operands driven on mul_x/mul_y to product on mul_result
FIFO_DEPTH, 8, response FIFO entries and total credit; must be >= MUL_LATENCY+1 for full throughput

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_x  in  NUM_REQ*MUL_W  operand x, requester i at [i*MUL_W +: MUL_W]
req_y  in  NUM_REQ*MUL_W  operand y, same packing
req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
mul_x  out  MUL_W  multiplier operand x
mul_y  out  MUL_W  multiplier operand y
mul_result  in  MUL_W  multiplier product (low MUL_W bits)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  $clog2(NUM_REQ)  index of the originating requester
rsp_data  out  MUL_W  product
busy  out  1  any request in flight or buffered

Behaviour:
- Reset (async, active-high): tag pipe cleared, FIFO emptied, credit count 0, RR pointer 0. rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0. Products in flight at reset are discarded.
- Credit: cnt = issued-but-not-popped count, range 0..FIFO_DEPTH. Issue is allowed only when cnt < FIFO_DEPTH, using the registered value; pops in the same cycle do not free a credit until the next cycle.
- Arbitration (combinational): if issue is allowed, grant the first i with req_valid[i] set, searching from ptr upward with wrap. req_ready is one-hot or zero, and never asserts without req_valid.
- On a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- mul_x/mul_y equal the granted operands. With no grant they are 0.
- Tag pipe: MUL_LATENCY stages of {vld, id}. Stage0 captures {grant_any, grant_id} on the issue edge, so stage MUL_LATENCY-1 is aligned with mul_result. mul_result is ignored when that stage's vld=0, which covers zero and stale multiplier contents.
- FIFO push: when the last tag stage has vld=1, {id, mul_result} is pushed on the same edge. Overflow is impossible by credit and is flagged by an assertion.
- FIFO is first-word-fall-through: rsp_valid = !empty, and rsp_id/rsp_data come from the head register. Pop on rsp_valid && rsp_ready.
- rsp_valid is independent of rsp_ready. When held, rsp_data/rsp_id stay stable until popped.
- Latency: request accepted at edge E delivers rsp_valid in the cycle after edge E+MUL_LATENCY (7 cycles by default).
- Ordering: strictly issue order.
- Throughput: 1 result/cycle with rsp_ready held high; steady-state cnt = MUL_LATENCY+1.
- cnt update: issue-only +1; pop-only -1; both or neither: unchanged.
- busy = (cnt != 0).
- Full FIFO with concurrent push and pop cannot occur, since cnt bounds FIFO occupancy plus in-flight count.
- Width: product is truncated mod 2^MUL_W, as computed by the multiplier. The arbiter performs no arithmetic.

Decomposition:
- Package iddmm_mul_pkg: MUL_W, MUL_LATENCY constants; ID_W = $clog2(NUM_REQ); typedef mul_tag_t {vld, id}; typedef mul_rsp_t {id, data}.
- One sub-module: iddmm_mul_rsp_fifo, a synchronous FWFT FIFO parameterized by depth and mul_rsp_t, with async active-high reset.
- Round-robin grant logic stays inline.

Test Plan:
1. Multiplier model attached. Requester 2 sends x=3, y=5 at cycle 0 with rsp_ready=1 -> rsp_valid only at cycle 7; rsp_id=2, rsp_data=15; busy falls at cycle 8.
2. All four req_valid held high with distinct operands, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle with no bubbles; responses in the same id order at 1/cycle; cnt settles at 7.
3. rsp_ready=0, all requesters valid -> exactly 8 grants, then req_ready=0 while cnt=8. Raise rsp_ready -> 8 responses in issue order, and the first new grant comes one cycle after the first pop.
4. Wrap: x=y=2^128-1 -> rsp_data=1. x=y=2^64 -> rsp_data=0. x=2^127, y=2 -> rsp_data=0.
5. Assert rst with 3 products in flight and 2 in the FIFO -> outputs zero immediately (async). After release, with mul_result still non-zero from stale products, no rsp_valid appears, and cnt=0, ptr=0.
6. At cnt=8, pop and a pending request occur in the same cycle -> no grant that cycle, cnt=7 next cycle, grant the following cycle.
